// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

    // Scan FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHOW  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    localparam int NUM_DIGITS = 4;

    // All anodes released (active-low drive)
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHOW  = ST_SHOW,
        S_GUARD = ST_GUARD
    } state_t;

    // Four BCD digits, index 3 is the most significant
    typedef logic [NUM_DIGITS-1:0][3:0] bcd_word_t;

endpackage

// File: rtl/scan_slot_timer.sv
// Slot timer: counts cycles spent in the current scan state, flags the last one.
// Latency: terminal count asserts combinationally from the registered count.
// Backpressure: none; reload restarts the count at 0 on the next edge.
module scan_slot_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         reload,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    // Restart at zero whenever the owner changes state, otherwise advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (reload) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan: lights one digit per slot, guards between digits,
// skips masked digits and blanks leading zeros. Outputs registered, 1 cycle after inputs.
// Backpressure: none; en low returns to IDLE on the next edge.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    input  logic                  blank_lz,
    input  logic [3:0]            number0,
    input  logic [3:0]            number1,
    input  logic [3:0]            number2,
    input  logic [3:0]            number3,
    output logic [1:0]            scan_cnt,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  blank,
    output logic                  frame_tick
);

    localparam int MAX_CYC = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
    localparam int CW      = $clog2(MAX_CYC);

    state_t          state, state_next;
    logic [1:0]      scan_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic            blank_next;
    logic            tick_next;
    bcd_word_t       snap, snap_next;
    bcd_word_t       num_in;
    logic [CW-1:0]   slot_last;
    logic            slot_done;

    assign num_in = {number3, number2, number1, number0};

    // Lowest enabled digit index; mask is known non-zero where this is used
    function automatic logic [1:0] lowest_enabled(input logic [NUM_DIGITS-1:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Next enabled digit strictly above cur, wrapping 3->0; returns cur when it is the only one
    function automatic logic [1:0] next_enabled(input logic [NUM_DIGITS-1:0] m,
                                                input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] j;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            j = cur + 2'(k);
            if (!found && m[j]) begin
                r     = j;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // A digit is a leading zero when it and every more significant digit are zero
    function automatic logic lz_blank(input bcd_word_t s, input logic [1:0] idx,
                                      input logic lz);
        logic all_zero;
        all_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && s[j] != 4'd0) all_zero = 1'b0;
        end
        return lz && (idx != 2'd0) && all_zero;
    endfunction

    // Slot length depends on whether a digit is lit or in the dark guard gap
    assign slot_last = (state == S_SHOW) ? CW'(REFRESH_DIV - 1) : CW'(GUARD_CYC - 1);

    scan_slot_timer #(
        .W(CW)
    ) u_slot_timer (
        .clk   (clk),
        .rst   (rst),
        .reload(state_next != state),
        .last  (slot_last),
        .tc    (slot_done)
    );

    // Next state, next digit, frame snapshot and the registered output values
    always_comb begin
        state_next = state;
        scan_next  = scan_cnt;
        snap_next  = snap;
        tick_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && digit_mask != '0) begin
                    state_next = S_SHOW;
                    scan_next  = lowest_enabled(digit_mask);
                    snap_next  = num_in;
                    tick_next  = 1'b1;
                end
            end
            S_SHOW: begin
                if (!en) begin
                    state_next = S_IDLE;
                end else if (slot_done) begin
                    state_next = S_GUARD;
                end
            end
            S_GUARD: begin
                if (!en) begin
                    state_next = S_IDLE;
                end else if (slot_done) begin
                    if (digit_mask == '0) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_SHOW;
                        scan_next  = next_enabled(digit_mask, scan_cnt);
                        // Wrapping to an index at or below the old one starts a new frame
                        if (scan_next <= scan_cnt) begin
                            snap_next = num_in;
                            tick_next = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        an_next    = AN_OFF;
        blank_next = 1'b1;
        if (state_next == S_SHOW) begin
            an_next    = ~(4'b0001 << scan_next);
            blank_next = lz_blank(snap_next, scan_next, blank_lz);
        end
    end

    // State, snapshot and every output register update together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            scan_cnt   <= 2'd0;
            an         <= AN_OFF;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
            snap       <= '0;
        end else begin
            state      <= state_next;
            scan_cnt   <= scan_next;
            an         <= an_next;
            blank      <= blank_next;
            frame_tick <= tick_next;
            snap       <= snap_next;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with REFRESH_DIV=4, GUARD_CYC=2.
// A slot-level reference model is stepped every clock and compared on the falling edge.
// Table vectors check frame length, lit set and blanking; directed sequences cover corners.
module tb_display_scan_controller;

    localparam int R = 4;
    localparam int G = 2;
    localparam int P_IDLE = 0;
    localparam int P_LIT  = 1;
    localparam int P_DARK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] digit_mask;
    logic       blank_lz;
    logic [3:0] number0, number1, number2, number3;
    logic [1:0] scan_cnt;
    logic [3:0] an;
    logic       blank;
    logic       frame_tick;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which phase, which digit, cycles left, frame snapshot
    int m_phase;
    int m_left;
    int m_cur;
    int m_snap[4];
    bit m_tick;
    bit m_lz;

    typedef struct {
        logic [3:0] mask;
        logic       lz;
        logic [3:0] n3, n2, n1, n0;
        int         frame_len;
        logic [3:0] lit;
        logic [3:0] blk;
    } vec_t;

    vec_t vecs[7];

    display_scan_controller #(
        .REFRESH_DIV(R),
        .GUARD_CYC  (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digit_mask(digit_mask),
        .blank_lz  (blank_lz),
        .number0   (number0),
        .number1   (number1),
        .number2   (number2),
        .number3   (number3),
        .scan_cnt  (scan_cnt),
        .an        (an),
        .blank     (blank),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out, required event never seen at %0t", name, $time);
    endtask

    task automatic m_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_cur   = 0;
        m_tick  = 0;
        m_lz    = 0;
        for (int i = 0; i < 4; i++) m_snap[i] = 0;
    endtask

    task automatic start_frame();
        m_snap[0] = int'(number0);
        m_snap[1] = int'(number1);
        m_snap[2] = int'(number2);
        m_snap[3] = int'(number3);
        m_tick = 1;
    endtask

    // Leading zero: the decimal value of the snapshot has no digit at or above position cur
    function automatic bit model_blank();
        int value;
        int p;
        value = m_snap[3] * 1000 + m_snap[2] * 100 + m_snap[1] * 10 + m_snap[0];
        p = 1;
        for (int i = 0; i < m_cur; i++) p = p * 10;
        return m_lz && (m_cur > 0) && (value / p == 0);
    endfunction

    function automatic logic [7:0] exp_outs();
        logic [3:0] a;
        logic       b;
        a = 4'hF;
        b = 1'b1;
        if (m_phase == P_LIT) begin
            a = ~(4'b0001 << m_cur);
            b = model_blank();
        end
        return {2'(m_cur), a, b, m_tick};
    endfunction

    // Advance the model by one rising edge using the inputs applied before it
    task automatic model_edge();
        int nxt;
        m_tick = 0;
        m_lz   = blank_lz;
        if (rst) begin
            m_reset();
        end else if (!en) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (digit_mask != 4'd0) begin
                        for (int i = 3; i >= 0; i--) if (digit_mask[i]) m_cur = i;
                        start_frame();
                        m_phase = P_LIT;
                        m_left  = R;
                    end
                end
                P_LIT: begin
                    if (m_left == 1) begin
                        m_phase = P_DARK;
                        m_left  = G;
                    end else begin
                        m_left--;
                    end
                end
                default: begin
                    if (m_left > 1) begin
                        m_left--;
                    end else if (digit_mask == 4'd0) begin
                        m_phase = P_IDLE;
                    end else begin
                        nxt = m_cur;
                        for (int k = 4; k >= 1; k--)
                            if (digit_mask[(m_cur + k) % 4]) nxt = (m_cur + k) % 4;
                        if (nxt <= m_cur) start_frame();
                        m_cur   = nxt;
                        m_phase = P_LIT;
                        m_left  = R;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("outs", {24'd0, scan_cnt, an, blank, frame_tick}, {24'd0, exp_outs()});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        bit ok;
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            if (an == target) begin
                ok = 1;
                break;
            end
            cycle();
        end
        if (!ok) fail_timeout(name);
    endtask

    initial begin
        int         order[$];
        int         len, mism;
        logic [3:0] lit;
        bit         got;
        logic [3:0] prev_an;

        vecs[0] = '{4'b1111, 1'b0, 4'd4, 4'd3, 4'd2, 4'd1, 24, 4'b1111, 4'b0000};
        vecs[1] = '{4'b0101, 1'b0, 4'd4, 4'd3, 4'd2, 4'd1, 12, 4'b0101, 4'b0000};
        vecs[2] = '{4'b1111, 1'b1, 4'd0, 4'd0, 4'd4, 4'd7, 24, 4'b1111, 4'b1100};
        vecs[3] = '{4'b1111, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 24, 4'b1111, 4'b1110};
        vecs[4] = '{4'b1000, 1'b0, 4'd9, 4'd0, 4'd0, 4'd0,  6, 4'b1000, 4'b0000};
        vecs[5] = '{4'b1111, 1'b1, 4'd0, 4'd5, 4'd0, 4'd0, 24, 4'b1111, 4'b1000};
        vecs[6] = '{4'b0110, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 12, 4'b0110, 4'b0110};

        rst = 1'b1; en = 1'b0; digit_mask = 4'd0; blank_lz = 1'b0;
        number0 = 4'd1; number1 = 4'd2; number2 = 4'd3; number3 = 4'd4;
        m_reset();
        #12;
        check("rst_scan", {30'd0, scan_cnt}, 32'd0);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_blank", {31'd0, blank}, 32'd1);
        check("rst_tick", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full sweep: first lit cycle right after en, then digits 0..3 and a 24-cycle frame
        digit_mask = 4'b1111;
        en = 1'b1;
        cycle();
        check("first_lit_an", {28'd0, an}, 32'hE);
        check("first_tick", {31'd0, frame_tick}, 32'd1);
        prev_an = an;
        order.push_back(int'(scan_cnt));
        for (int c = 0; c < 24; c++) begin
            cycle();
            if (an != 4'hF && an != prev_an) order.push_back(int'(scan_cnt));
            prev_an = an;
        end
        check("frame24_tick", {31'd0, frame_tick}, 32'd1);
        check("scan_order_len", order.size(), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check("scan_order", order[i], i % 4);

        // Table of mask / suppression scenarios
        for (int v = 0; v < 7; v++) begin
            do_reset();
            digit_mask = vecs[v].mask;
            blank_lz   = vecs[v].lz;
            number3 = vecs[v].n3; number2 = vecs[v].n2;
            number1 = vecs[v].n1; number0 = vecs[v].n0;
            en = 1'b1;
            got = 0;
            for (int c = 0; c < 50; c++) begin
                cycle();
                if (frame_tick) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                fail_timeout("vec_first_tick");
            end else begin
                lit = 4'd0; mism = 0; len = 0; got = 0;
                for (int c = 0; c < 200; c++) begin
                    if (an != 4'hF) begin
                        lit = lit | ~an;
                        if (blank !== vecs[v].blk[scan_cnt]) mism++;
                    end
                    len++;
                    cycle();
                    if (frame_tick) begin
                        got = 1;
                        break;
                    end
                end
                if (!got) fail_timeout("vec_next_tick");
                check("vec_frame_len", len, vecs[v].frame_len);
                check("vec_lit_set", {28'd0, lit}, {28'd0, vecs[v].lit});
                check("vec_blank_errs", mism, 32'd0);
            end
        end

        // Drop en while digit 2 is lit, then re-enable
        do_reset();
        digit_mask = 4'b1111; blank_lz = 1'b0; en = 1'b1;
        wait_an(4'b1011, "wait_digit2");
        cycle();
        en = 1'b0;
        cycle();
        check("en_drop_an", {28'd0, an}, 32'hF);
        check("en_drop_blank", {31'd0, blank}, 32'd1);
        repeat (3) cycle();
        en = 1'b1;
        cycle();
        check("reen_an", {28'd0, an}, 32'hE);
        check("reen_tick", {31'd0, frame_tick}, 32'd1);

        // Asynchronous reset in the guard after digit 1
        wait_an(4'b1101, "wait_digit1");
        wait_an(4'hF, "wait_guard1");
        rst = 1'b1;
        #1;
        m_reset();
        check("rstg_scan", {30'd0, scan_cnt}, 32'd0);
        check("rstg_an", {28'd0, an}, 32'hF);
        check("rstg_blank", {31'd0, blank}, 32'd1);
        check("rstg_tick", {31'd0, frame_tick}, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // Mask cleared in the guard after digit 2: park in IDLE keeping scan_cnt
        wait_an(4'b1011, "wait_digit2b");
        wait_an(4'hF, "wait_guard2");
        digit_mask = 4'd0;
        repeat (6) cycle();
        check("mask0_an", {28'd0, an}, 32'hF);
        check("mask0_scan", {30'd0, scan_cnt}, 32'd2);
        check("mask0_blank", {31'd0, blank}, 32'd1);

        // Snapshot: a mid-frame change is not seen until the next frame
        do_reset();
        digit_mask = 4'b1001; blank_lz = 1'b1;
        number3 = 4'd5; number2 = 4'd0; number1 = 4'd0; number0 = 4'd0;
        en = 1'b1;
        cycle();
        number3 = 4'd0;
        wait_an(4'b0111, "wait_snap_old");
        check("snap_hold_blank", {31'd0, blank}, 32'd0);
        wait_an(4'b1110, "wait_snap_frame");
        check("snap_new_tick", {31'd0, frame_tick}, 32'd1);
        wait_an(4'b0111, "wait_snap_new");
        check("snap_new_blank", {31'd0, blank}, 32'd1);

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) digit_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 9) == 0) begin
                number0 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
                number1 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
                number2 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
                number3 = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #1;
                m_reset();
                check("rand_async_rst", {24'd0, scan_cnt, an, blank, frame_tick},
                      {24'd0, exp_outs()});
                cycle();
                rst = 1'b0;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
